// File: rtl/rsa_pkg.sv
// Shared RSA-path definitions: default bus width, octet size and loader state encoding.
package rsa_pkg;

    localparam int DATA_BIT_WIDTH_DEF = 2048;
    localparam int OCTET_W            = 8;
    localparam int OCTETS_DEF         = DATA_BIT_WIDTH_DEF / OCTET_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;

endpackage

// File: rtl/octet_stream_loader.sv
// Byte-serial octet string to big-endian DATA_BIT_WIDTH bus, held until acknowledged.
// Optional LEN_CHECK_EN: overlong strings are drained and flagged on o_err.
module octet_stream_loader
    import rsa_pkg::*;
#(
    parameter int  DATA_BIT_WIDTH = DATA_BIT_WIDTH_DEF,
    localparam int OCTETS         = DATA_BIT_WIDTH / OCTET_W,
    localparam int LEN_W          = $clog2(OCTETS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [OCTET_W-1:0]        s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [DATA_BIT_WIDTH-1:0] X,
    output logic                      o_valid,
    input  logic                      o_ack,
`ifdef LEN_CHECK_EN
    output logic                      o_err,
`endif
    output logic [LEN_W-1:0]          o_len
);

    loader_state_t             state;
    logic [DATA_BIT_WIDTH-1:0] shift_q;
    logic [LEN_W-1:0]          count;
    logic [LEN_W-1:0]          count_next;
    logic                      take;
    logic                      full_next;

    assign take       = s_valid && s_ready;
    assign count_next = count + LEN_W'(1);
    assign full_next  = (count_next == LEN_W'(OCTETS));

    // The shift register and count are the output registers; they only move in FILL.
    assign X     = shift_q;
    assign o_len = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            shift_q <= '0;
            count   <= '0;
            s_ready <= 1'b0;
            o_valid <= 1'b0;
`ifdef LEN_CHECK_EN
            o_err   <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (take) begin
                        shift_q <= {shift_q[DATA_BIT_WIDTH-OCTET_W-1:0], s_data};
                        count   <= count_next;
                        if (s_last) begin
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            o_valid <= 1'b1;
                        end else if (full_next) begin
`ifdef LEN_CHECK_EN
                            state   <= DRAIN;
`else
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            o_valid <= 1'b1;
`endif
                        end
                    end
                end
                HOLD: begin
                    // s_ready stays low here, giving one bubble cycle after the ack.
                    if (o_ack) begin
                        state   <= FILL;
                        o_valid <= 1'b0;
                        shift_q <= '0;
                        count   <= '0;
`ifdef LEN_CHECK_EN
                        o_err   <= 1'b0;
`endif
                    end
                end
`ifdef LEN_CHECK_EN
                DRAIN: begin
                    if (take && s_last) begin
                        state   <= HOLD;
                        s_ready <= 1'b0;
                        o_valid <= 1'b1;
                        o_err   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_octet_stream_loader.sv
// Directed self-checking bench for octet_stream_loader (default 2048-bit bus).
module tb_octet_stream_loader;

    localparam int W     = 2048;
    localparam int LEN_W = $clog2(W / 8) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [W-1:0]     X;
    logic             o_valid;
    logic             o_ack;
    logic [LEN_W-1:0] o_len;
`ifdef LEN_CHECK_EN
    logic             o_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_x;

    octet_stream_loader #(.DATA_BIT_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .X       (X),
        .o_valid (o_valid),
        .o_ack   (o_ack),
`ifdef LEN_CHECK_EN
        .o_err   (o_err),
`endif
        .o_len   (o_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pattern(input int n, input int start);
        logic [W-1:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[W-9:0], 8'((start + i) % 256)};
        return v;
    endfunction

    // Waits (bounded) for s_ready, then transfers one octet on the next edge.
    task automatic send(input logic [7:0] d, input logic last);
        int guard = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        while (!s_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic ack();
        o_ack = 1'b1;
        @(posedge clk); #1;
        o_ack = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [W-1:0] ex, input int len);
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_len"},   64'(o_len), 64'(len));
        check({tag, "_xlo"},   X[63:0], ex[63:0]);
        check({tag, "_xfull"}, 64'(X === ex), 64'd1);
    endtask

    initial begin
        reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; o_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_len",   64'(o_len), 64'd0);
        check("rst_x",     64'(X === '0), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready_after", 64'(s_ready), 64'd1);

        // 3-octet frame, o_valid the cycle after the last transfer
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
        exp_x = '0; exp_x[23:0] = 24'h010203;
        check_frame("f3", exp_x, 3);

        // hold stable with s_valid pushing; ack with s_valid in the same cycle
        s_data = 8'hEE; s_valid = 1'b1; s_last = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_frame("hold", exp_x, 3);
        o_ack = 1'b1;
        @(posedge clk); #1;
        o_ack = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        check("ack_valid", 64'(o_valid), 64'd0);
        check("ack_bubble", 64'(s_ready), 64'd0);
        check("ack_len", 64'(o_len), 64'd0);
        @(posedge clk); #1;
        check("ack_ready", 64'(s_ready), 64'd1);
        check("ack_len2", 64'(o_len), 64'd0);

        // ack outside HOLD and s_last without s_valid are ignored
        send(8'h77, 1'b0);
        ack();
        s_last = 1'b1;
        @(posedge clk); #1;
        s_last = 1'b0;
        check("stray_valid", 64'(o_valid), 64'd0);
        check("stray_len", 64'(o_len), 64'd1);
        send(8'h88, 1'b1);
        exp_x = '0; exp_x[15:0] = 16'h7788;
        check_frame("f2", exp_x, 2);
        ack();

        // 1-octet frame
        send(8'h5A, 1'b1);
        exp_x = '0; exp_x[7:0] = 8'h5A;
        check_frame("f1", exp_x, 1);
        ack();

        // exactly OCTETS octets with s_last on the last
        for (int i = 0; i < 256; i++) send(8'(i), i == 255);
        exp_x = pattern(256, 0);
        check_frame("f256", exp_x, 256);
        check("f256_top", 64'(X[W-1:W-8]), 64'h00);
        ack();

        // reset mid-frame discards partial data
        for (int i = 0; i < 100; i++) send(8'(i + 7), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_len", 64'(o_len), 64'd0);
        check("mid_rst_x", 64'(X === '0), 64'd1);
        check("mid_rst_ready", 64'(s_ready), 64'd0);
        send(8'hAB, 1'b0); send(8'hCD, 1'b1);
        exp_x = '0; exp_x[15:0] = 16'hABCD;
        check_frame("fab", exp_x, 2);
        ack();

        // 300-octet string
`ifdef LEN_CHECK_EN
        for (int i = 0; i < 300; i++) send(8'(i), i == 299);
        check_frame("ovr", pattern(256, 0), 256);
        check("ovr_err", 64'(o_err), 64'd1);
        ack();
        check("ovr_err_clr", 64'(o_err), 64'd0);
`else
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
        check_frame("ovr_a", pattern(256, 0), 256);
        ack();
        for (int i = 256; i < 300; i++) send(8'(i), i == 299);
        check_frame("ovr_b", pattern(44, 256), 44);
        check("ovr_b_lo", 64'(X[15:0]), 64'h2A2B);
        ack();
`endif

        // back-to-back frames with s_valid held high across the ack
        send(8'h11, 1'b0); send(8'h22, 1'b1);
        exp_x = '0; exp_x[15:0] = 16'h1122;
        check_frame("bb1", exp_x, 2);
        s_data = 8'h33; s_valid = 1'b1; s_last = 1'b0;
        ack();
        check("bb_bubble", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        check("bb_ready", 64'(s_ready), 64'd1);
        check("bb_len0", 64'(o_len), 64'd0);
        @(posedge clk); #1;
        check("bb_len1", 64'(o_len), 64'd1);
        s_data = 8'h44; s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        exp_x = '0; exp_x[15:0] = 16'h3344;
        check_frame("bb2", exp_x, 2);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/octet_stream_loader.md
Name: octet_stream_loader

Overview:
- Upstream feeder for the OS2IP stage in the RSA path.
- Accepts a byte-serial octet string (e.g. from the network receive path) over a valid/ready handshake.
- Assembles the bytes into a DATA_BIT_WIDTH-wide bus, first octet most significant, right-aligned with zero left-padding. The bus value therefore equals the big-endian integer of the octets.
- Presents the bus with a hold-until-acknowledged valid to the OS2IP stage.

Parameters:
- DATA_BIT_WIDTH, 2048, width of assembled octet-string bus; must be a multiple of 8.
- OCTETS, DATA_BIT_WIDTH/8 (localparam), maximum octets per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- s_data  input  8  incoming octet.
- s_valid  input  1  s_data valid.
- s_last  input  1  qualifies final octet of the string (sampled with s_valid).
- s_ready  output  1  loader can accept an octet.
- X  output  DATA_BIT_WIDTH  assembled octet string to OS2IP.
- o_valid  output  1  X stable and complete.
- o_ack  input  1  downstream has consumed X.
- o_len  output  $clog2(OCTETS)+1  number of octets in X (1..OCTETS).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: X=0, o_valid=0, o_len=0, s_ready=0 for the reset cycle, then 1. Internal count=0, state=FILL.
- States: FILL, HOLD (plus DRAIN when LEN_CHECK_EN).
- FILL:
  - s_ready=1.
  - An octet transfers when s_valid&&s_ready on a rising edge. Then buf <= {buf[DATA_BIT_WIDTH-9:0], s_data} and count <= count+1.
  - Go to HOLD if s_last=1 on the transfer, or if count+1==OCTETS (bus full).
- HOLD:
  - s_ready=0, o_valid=1, X=buf, o_len=count. X and o_len do not change while o_valid=1.
  - On o_ack=1: o_valid drops next cycle, buf and count clear to 0, return to FILL.
  - s_ready becomes 1 the cycle after the ack, so there is one bubble cycle.
- Latency: o_valid asserts the cycle after the final octet transfer.
- Throughput: 1 octet/cycle in FILL.
- Boundaries:
  - 1-octet frame: X = {zeros, octet}, o_len=1.
  - Exactly OCTETS octets with s_last on the last one: normal HOLD.
  - o_ack while not in HOLD: ignored.
  - o_ack and s_valid in the same HOLD cycle: octet is not taken (s_ready=0).
  - s_last without s_valid: ignored.
  - Reset mid-frame or in HOLD: partial data discarded, all outputs return to reset values next cycle.
- Downstream note: OS2IP needs valid held continuously until it finishes. o_valid satisfies this because it is held until o_ack.

Optional Feature:
- Macro: LEN_CHECK_EN.
- Defined:
  - Adds output o_err (1 bit, reset 0).
  - If the OCTETS-th octet transfers without s_last, enter DRAIN instead of HOLD.
  - DRAIN: s_ready=1; octets are discarded and buf is unchanged until a transfer with s_last, then HOLD with o_err=1.
  - o_err clears on o_ack together with o_valid.
- Not defined:
  - No o_err port, no DRAIN state.
  - A full bus ends the frame; following octets start a new frame after the ack.

Decomposition:
- Shared package rsa_pkg:
  - DATA_BIT_WIDTH default (2048).
  - OCTET_W=8.
  - OCTETS.
  - Loader state enum typedef (FILL, HOLD, DRAIN).
- Single module; no sub-module needed. The shift-register and counter are trivial, so a separate byte-packer would only add ports.

Test Plan:
- Reset, then 3 octets 0x01,0x02,0x03 with s_last on 0x03 → next cycle o_valid=1, X=0x010203 (upper bits 0), o_len=3, s_ready=0.
- Hold o_ack=0 for 10 cycles while driving s_valid → X, o_len stable, no octets accepted. Pulse o_ack → o_valid=0 next cycle, s_ready=1 the cycle after.
- 256 octets of value i (0..255), s_last on the last one → X[2047:2040]=0x00, X[7:0]=0xFF, o_len=256. Chain into OS2IP → OS2IP x equals X.
- Reset asserted after 100 octets, then a 2-octet frame 0xAB,0xCD → X=0xABCD, o_len=2 (no stale data).
- LEN_CHECK_EN defined: 300 octets with s_last on the 300th → o_err=1, o_len=256, X holds the first 256 octets, 44 octets drained. Without the macro → first frame o_len=256; after ack, second frame holds the remaining 44 octets, o_len=44.
- Back-to-back frames with s_valid always high: 1 bubble cycle between the ack and the next accept. Both frames are correct.
